// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 2-read/1-write synchronous SRAM among NUM_REQ clients.
// Optional same-address write-to-read bypass enabled by defining SRAM_ARB_RAW_FWD_EN.
module sram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SIZE       = 16,
  parameter int WIDTH      = 4,
  parameter int ADDR_WIDTH = $clog2(SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            reqRd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqRdAddr,
  output logic [NUM_REQ-1:0]            gntRd,
  input  logic [NUM_REQ-1:0]            reqWr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqWrAddr,
  input  logic [NUM_REQ*WIDTH-1:0]      reqWrData,
  output logic [NUM_REQ-1:0]            gntWr,
  output logic [NUM_REQ-1:0]            rdValid,
  output logic [NUM_REQ*WIDTH-1:0]      rdData,
  output logic                          sramEn,
  output logic                          sramR1,
  output logic                          sramR2,
  output logic                          sramW,
  output logic [ADDR_WIDTH-1:0]         sramR1Addr,
  output logic [ADDR_WIDTH-1:0]         sramR2Addr,
  output logic [ADDR_WIDTH-1:0]         sramWAddr,
  output logic [WIDTH-1:0]              sramIn,
  input  logic [WIDTH-1:0]              sramOut1,
  input  logic [WIDTH-1:0]              sramOut2
);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t inc(input ptr_t p);
    return (p == ptr_t'(NUM_REQ - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Returns {found, index} of the first set request at or after start, circularly.
  function automatic logic [PTR_W:0] pick(input logic [NUM_REQ-1:0] req, input ptr_t start);
    logic [PTR_W:0] res;
    ptr_t           idx;
    res = '0;
    idx = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[idx] && !res[PTR_W]) res = {1'b1, idx};
      idx = inc(idx);
    end
    return res;
  endfunction

  ptr_t r_rd_ptr, r_wr_ptr, r_o1, r_o2;
  logic r_v1, r_v2;

  logic [NUM_REQ-1:0]    w_req_rd, w_req_rd_b, w_req_wr;
  logic [PTR_W:0]        w_pick_a, w_pick_b, w_pick_w;
  logic                  w_a_vld, w_b_vld, w_w_vld;
  ptr_t                  w_a_idx, w_b_idx, w_w_idx;
  logic [ADDR_WIDTH-1:0] w_a_addr, w_b_addr, w_w_addr;
  logic [WIDTH-1:0]      w_w_data, w_out1, w_out2;

  assign w_req_rd = rst ? '0 : reqRd;
  assign w_req_wr = rst ? '0 : reqWr;

  assign w_pick_a = pick(w_req_rd, r_rd_ptr);
  assign w_a_vld  = w_pick_a[PTR_W];
  assign w_a_idx  = w_pick_a[PTR_W-1:0];

  // Port 2 searches from just past winner A with A masked out; empty if A found nothing.
  always_comb begin
    w_req_rd_b          = w_req_rd;
    w_req_rd_b[w_a_idx] = 1'b0;
  end
  assign w_pick_b = pick(w_req_rd_b, inc(w_a_idx));
  assign w_b_vld  = w_pick_b[PTR_W];
  assign w_b_idx  = w_pick_b[PTR_W-1:0];

  assign w_pick_w = pick(w_req_wr, r_wr_ptr);
  assign w_w_vld  = w_pick_w[PTR_W];
  assign w_w_idx  = w_pick_w[PTR_W-1:0];

  assign w_a_addr = reqRdAddr[w_a_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_b_addr = reqRdAddr[w_b_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_w_addr = reqWrAddr[w_w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_w_data = reqWrData[w_w_idx*WIDTH +: WIDTH];

  always_comb begin
    gntRd = '0;
    gntWr = '0;
    if (w_a_vld) gntRd[w_a_idx] = 1'b1;
    if (w_b_vld) gntRd[w_b_idx] = 1'b1;
    if (w_w_vld) gntWr[w_w_idx] = 1'b1;
  end

  assign sramR1     = w_a_vld;
  assign sramR2     = w_b_vld;
  assign sramW      = w_w_vld;
  assign sramEn     = w_a_vld | w_b_vld | w_w_vld;
  assign sramR1Addr = w_a_vld ? w_a_addr : '0;
  assign sramR2Addr = w_b_vld ? w_b_addr : '0;
  assign sramWAddr  = w_w_vld ? w_w_addr : '0;
  assign sramIn     = w_w_vld ? w_w_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_o1     <= '0;
      r_o2     <= '0;
    end else begin
      // Pointer moves past the last reader served this cycle.
      if (w_b_vld)      r_rd_ptr <= inc(w_b_idx);
      else if (w_a_vld) r_rd_ptr <= inc(w_a_idx);
      if (w_w_vld)      r_wr_ptr <= inc(w_w_idx);
      r_v1 <= w_a_vld;
      r_o1 <= w_a_idx;
      r_v2 <= w_b_vld;
      r_o2 <= w_b_idx;
    end
  end

`ifdef SRAM_ARB_RAW_FWD_EN
  logic             r_fwd1, r_fwd2;
  logic [WIDTH-1:0] r_fwd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd1     <= 1'b0;
      r_fwd2     <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd1     <= w_a_vld && w_w_vld && (w_a_addr == w_w_addr);
      r_fwd2     <= w_b_vld && w_w_vld && (w_b_addr == w_w_addr);
      r_fwd_data <= w_w_data;
    end
  end

  assign w_out1 = r_fwd1 ? r_fwd_data : sramOut1;
  assign w_out2 = r_fwd2 ? r_fwd_data : sramOut2;
`else
  assign w_out1 = sramOut1;
  assign w_out2 = sramOut2;
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ret
    logic w_hit1, w_hit2;
    assign w_hit1      = r_v1 && (r_o1 == ptr_t'(gi));
    assign w_hit2      = r_v2 && (r_o2 == ptr_t'(gi));
    assign rdValid[gi] = w_hit1 | w_hit2;
    assign rdData[gi*WIDTH +: WIDTH] = w_hit1 ? w_out1 : (w_hit2 ? w_out2 : '0);
  end
endmodule
